// File: rtl/regread.sv
// Register-file reader: fetches num_reg words one at a time and hands each to a consumer.
// Define REGREAD_WRAP_EN to wrap the address instead of parking in EXHAUST after the last register.
module regread #(
  parameter int width      = 8,
  parameter int num_reg    = 4,
  parameter int addr_width = (num_reg > 1) ? $clog2(num_reg) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  new_transfer,
  input  logic                  data_request,
  input  logic                  transfer_done,
  output logic [width-1:0]      data_out,
  output logic                  data_valid,
  output logic [addr_width-1:0] read_addr,
  output logic                  read_enable,
  input  logic [width-1:0]      read_data,
  output logic                  read_done,
  output logic                  underrun
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD,
    EXHAUST
  } state_t;

  localparam logic [addr_width-1:0] last_addr = addr_width'(num_reg - 1);

  state_t                  state, state_next;
  logic [addr_width-1:0]   addr_next;
  logic [width-1:0]        data_next;
  logic                    valid_next;
  logic                    enable_next;
  logic                    done_next;
  logic                    underrun_next;
  logic                    ending;

  // transfer_done only has an effect once a transfer is under way
  assign ending = transfer_done && (state != IDLE);

  always_comb begin
    state_next    = state;
    addr_next     = read_addr;
    data_next     = data_out;
    valid_next    = data_valid;
    enable_next   = 1'b0;
    done_next     = 1'b0;
    underrun_next = data_request && !data_valid && !ending;

    if (ending) begin
      done_next  = 1'b1;
      state_next = IDLE;
      valid_next = 1'b0;
    end

    // A new transfer overrides everything else, including a simultaneous end
    if (new_transfer) begin
      state_next  = FETCH;
      addr_next   = '0;
      valid_next  = 1'b0;
      enable_next = 1'b1;
    end else if (!ending) begin
      case (state)
        IDLE: begin
        end
        FETCH: begin
          state_next = WAIT;
        end
        WAIT: begin
          data_next  = read_data;
          valid_next = 1'b1;
          state_next = HOLD;
        end
        HOLD: begin
          if (data_request) begin
            if (read_addr == last_addr) begin
`ifdef REGREAD_WRAP_EN
              addr_next   = '0;
              state_next  = FETCH;
              enable_next = 1'b1;
              valid_next  = 1'b0;
`else
              // Out of registers: park with a valid zero word, no further reads
              state_next  = EXHAUST;
              data_next   = '0;
              valid_next  = 1'b1;
`endif
            end else begin
              addr_next   = read_addr + addr_width'(1);
              state_next  = FETCH;
              enable_next = 1'b1;
              valid_next  = 1'b0;
            end
          end
        end
        EXHAUST: begin
          data_next  = '0;
          valid_next = 1'b1;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      read_addr   <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      read_enable <= 1'b0;
      read_done   <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state       <= state_next;
      read_addr   <= addr_next;
      data_out    <= data_next;
      data_valid  <= valid_next;
      read_enable <= enable_next;
      read_done   <= done_next;
      underrun    <= underrun_next;
    end
  end

endmodule

// File: tb/tb_regread.sv
// Table-driven bench for regread (width=5, num_reg=3, register file 0x11, 0x05, 0x1A).
// Expected values follow REGREAD_WRAP_EN when the bench is compiled with it.
module tb_regread;

  logic       clk;
  logic       rst_n;
  logic       new_transfer;
  logic       data_request;
  logic       transfer_done;
  logic [4:0] data_out;
  logic       data_valid;
  logic [1:0] read_addr;
  logic       read_enable;
  logic [4:0] read_data;
  logic       read_done;
  logic       underrun;

  int tests;
  int failed;
  int re_count;
  int rd_count;

  logic [4:0] regs [3];

  typedef struct {
    logic       rst;
    logic       nt;
    logic       dr;
    logic       td;
    logic [4:0] dout;
    logic       dv;
    logic       re;
    logic [1:0] ra;
    logic       rd;
    logic       ur;
    logic       chk_cnt;
    int         exp_re;
    int         exp_rd;
  } vec_t;

  vec_t vecs[$];

  regread #(
    .width  (5),
    .num_reg(3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .new_transfer (new_transfer),
    .data_request (data_request),
    .transfer_done(transfer_done),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .read_addr    (read_addr),
    .read_enable  (read_enable),
    .read_data    (read_data),
    .read_done    (read_done),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: data appears the cycle after the strobe, poison otherwise
  always @(posedge clk) begin
    if (read_enable && read_addr < 2'd3) read_data <= regs[read_addr];
    else read_data <= 5'h1F;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (read_enable) re_count++;
    if (read_done) rd_count++;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    new_transfer  = 1'b0;
    data_request  = 1'b0;
    transfer_done = 1'b0;
    re_count      = 0;
    rd_count      = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic add(input logic rst, input logic nt, input logic dr, input logic td,
                     input logic [4:0] dout, input logic dv, input logic re,
                     input logic [1:0] ra, input logic rd, input logic ur);
    vec_t v;
    v.rst = rst; v.nt = nt; v.dr = dr; v.td = td;
    v.dout = dout; v.dv = dv; v.re = re; v.ra = ra; v.rd = rd; v.ur = ur;
    v.chk_cnt = 1'b0; v.exp_re = 0; v.exp_rd = 0;
    vecs.push_back(v);
  endtask

  task automatic add_cnt(input int exp_re, input int exp_rd);
    vecs[vecs.size()-1].chk_cnt = 1'b1;
    vecs[vecs.size()-1].exp_re  = exp_re;
    vecs[vecs.size()-1].exp_rd  = exp_rd;
  endtask

  // Reset, start, and read all three registers up to HOLD on 0x1A
  task automatic add_three_reads();
    add(1, 1, 0, 0, 5'h00, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 5'h00, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 5'h11, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 5'h11, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 5'h11, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 5'h05, 1, 0, 1, 0, 0);
    add(0, 0, 1, 0, 5'h05, 0, 1, 2, 0, 0);
    add(0, 0, 0, 0, 5'h05, 0, 0, 2, 0, 0);
    add(0, 0, 0, 0, 5'h1A, 1, 0, 2, 0, 0);
  endtask

  task automatic apply_stimulus(input vec_t v);
    if (v.rst) do_reset();
    new_transfer  = v.nt;
    data_request  = v.dr;
    transfer_done = v.td;
    tick();
    new_transfer  = 1'b0;
    data_request  = 1'b0;
    transfer_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, " data_out"}, 32'(data_out), 32'h0);
    check_output({tag, " data_valid"}, 32'(data_valid), 32'h0);
    check_output({tag, " read_addr"}, 32'(read_addr), 32'h0);
    check_output({tag, " read_enable"}, 32'(read_enable), 32'h0);
    check_output({tag, " read_done"}, 32'(read_done), 32'h0);
    check_output({tag, " underrun"}, 32'(underrun), 32'h0);
  endtask

  initial begin
    tests         = 0;
    failed        = 0;
    re_count      = 0;
    rd_count      = 0;
    regs[0]       = 5'h11;
    regs[1]       = 5'h05;
    regs[2]       = 5'h1A;
    rst_n         = 1'b1;
    new_transfer  = 1'b0;
    data_request  = 1'b0;
    transfer_done = 1'b0;

    // Full read of three words, then transfer_done
    add_three_reads();
`ifdef REGREAD_WRAP_EN
    add(0, 0, 1, 0, 5'h1A, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 5'h1A, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 5'h1A, 0, 0, 0, 0, 0);
    add_cnt(4, 1);
`else
    add(0, 0, 1, 0, 5'h00, 1, 0, 2, 0, 0);
    add(0, 0, 0, 1, 5'h00, 0, 0, 2, 1, 0);
    add(0, 0, 0, 0, 5'h00, 0, 0, 2, 0, 0);
    add_cnt(3, 1);
`endif

    // transfer_done while waiting for the first word
    add(1, 1, 0, 0, 5'h00, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 5'h00, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 5'h00, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 5'h00, 0, 0, 0, 0, 0);
    add_cnt(1, 1);

    // Five requests: end-of-registers behaviour
    add_three_reads();
`ifdef REGREAD_WRAP_EN
    add(0, 0, 1, 0, 5'h1A, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 5'h1A, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 5'h11, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 5'h11, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 5'h11, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 5'h05, 1, 0, 1, 0, 0);
    add(0, 0, 0, 1, 5'h05, 0, 0, 1, 1, 0);
    add_cnt(5, 1);
`else
    add(0, 0, 1, 0, 5'h00, 1, 0, 2, 0, 0);
    add(0, 0, 0, 0, 5'h00, 1, 0, 2, 0, 0);
    add(0, 0, 1, 0, 5'h00, 1, 0, 2, 0, 0);
    add(0, 0, 1, 0, 5'h00, 1, 0, 2, 0, 0);
    add(0, 0, 0, 1, 5'h00, 0, 0, 2, 1, 0);
    add_cnt(3, 1);
`endif

    // Early request underruns; restart with done; done beats request
    add(1, 1, 0, 0, 5'h00, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 5'h00, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 5'h11, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 5'h11, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 5'h11, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 5'h11, 1, 0, 0, 0, 0);
    add(0, 0, 1, 1, 5'h11, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 5'h11, 0, 0, 0, 0, 1);
    add_cnt(2, 2);

    // Reset state
    do_reset();
    check_all_zero("reset");

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("row%0d data_out", i), 32'(data_out), 32'(vecs[i].dout));
      check_output($sformatf("row%0d data_valid", i), 32'(data_valid), 32'(vecs[i].dv));
      check_output($sformatf("row%0d read_enable", i), 32'(read_enable), 32'(vecs[i].re));
      check_output($sformatf("row%0d read_addr", i), 32'(read_addr), 32'(vecs[i].ra));
      check_output($sformatf("row%0d read_done", i), 32'(read_done), 32'(vecs[i].rd));
      check_output($sformatf("row%0d underrun", i), 32'(underrun), 32'(vecs[i].ur));
      if (vecs[i].chk_cnt) begin
        check_output($sformatf("row%0d read_enable count", i), 32'(re_count), 32'(vecs[i].exp_re));
        check_output($sformatf("row%0d read_done count", i), 32'(rd_count), 32'(vecs[i].exp_rd));
      end
    end

    // Asynchronous reset while holding the word at address 1
    do_reset();
    new_transfer = 1'b1;
    tick();
    new_transfer = 1'b0;
    tick();
    tick();
    data_request = 1'b1;
    tick();
    data_request = 1'b0;
    tick();
    tick();
    check_output("hold1 data_out", 32'(data_out), 32'h05);
    check_output("hold1 read_addr", 32'(read_addr), 32'h1);
    check_output("hold1 data_valid", 32'(data_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    rd_count = 0;
    tick();
    tick();
    check_output("reset read_done count", 32'(rd_count), 32'h0);
    rst_n = 1'b1;
    new_transfer = 1'b1;
    tick();
    new_transfer = 1'b0;
    check_output("restart read_enable", 32'(read_enable), 32'h1);
    check_output("restart read_addr", 32'(read_addr), 32'h0);
    tick();
    tick();
    check_output("restart data_out", 32'(data_out), 32'h11);
    check_output("restart data_valid", 32'(data_valid), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
